// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and parity helpers for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Even mode makes the total count of ones (data + parity) even; odd mode inverts that.
    function automatic logic parity_of(input logic [7:0] b, input int mode);
        return (mode == PAR_ODD) ? ~(^b) : ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a one-cycle tick at terminal count
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [15:0] cnt;

    assign tick = (cnt == 16'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= 16'd0;
        end else if (tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART frame transmitter: start, 8 data bits LSB-first, optional parity, 1-2 stop bits
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_en,
    output logic       tx,
    output logic       ready,
    output logic       busy
);

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       par_bit;
    logic       tick;
    logic       clear;

    // Holding the counter at zero while idle guarantees a full-length start bit.
    assign clear = (state == S_IDLE);
    assign busy  = ~ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            ready   <= 1'b1;
            shreg   <= 8'd0;
            bit_idx <= 3'd0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_en) begin
                        shreg   <= data_in;
                        par_bit <= parity_of(data_in, PARITY);
                        state   <= S_START;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            if (PARITY != PAR_NONE) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx      <= 1'b1;
                        bit_idx <= 3'd0;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // bit_idx counts stop bits here so two-stop-bit frames reuse the same counter.
                    if (tick) begin
                        if (bit_idx == 3'(STOP_BITS - 1)) begin
                            state   <= S_IDLE;
                            ready   <= 1'b1;
                            bit_idx <= 3'd0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
